fd_chain: RTL and testbench
===========================

FD_CHAIN -- requirements
Module: fd_chain

Interface
REQ-001 SHALL have parameter NUM_STAGES, default 3: number of cascaded divider stages, range 1..8.
REQ-002 SHALL have parameter CNT_W, default 8: divisor and counter width per stage.
REQ-003 SHALL have parameter DIV_RST, default {8'd1,8'd10,8'd5}: packed NUM_STAGES*CNT_W reset divisors, stage 0 in the LSBs.
REQ-004 SHALL have port clock  input  1  sole clock; there is one clock and all logic is on it.
REQ-005 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port enable  input  1  run; low freezes every stage.
REQ-007 SHALL have port clear  input  1  synchronous clear of counters, square outputs, pending write and err.
REQ-008 SHALL have port div_wr_valid  input  1  divisor write request.
REQ-009 SHALL have port div_wr_stage  input  3  target stage index.
REQ-010 SHALL have port div_wr_value  input  CNT_W  new divisor.
REQ-011 SHALL have port div_wr_ready  output  1  write slot free.
REQ-012 SHALL have port tick  output  NUM_STAGES  one-cycle enable pulse per stage.
REQ-013 SHALL have port square  output  NUM_STAGES  toggle output per stage.
REQ-014 SHALL have port err  output  1  sticky bad-stage-index flag.

Function
REQ-015 Stage 0 SHALL count clock cycles while enable=1; stage k>0 SHALL count cycles where tick[k-1]=1.
REQ-016 tick[k] SHALL be 1 for exactly the cycle in which stage k counts at value div[k]-1, and the counter SHALL wrap to 0 in the same cycle.
REQ-017 Cascade SHALL be zero-latency: tick[k] coincides with the tick[k-1] that completes it (combinational carry chain).
REQ-018 div[k]=1 SHALL make tick[k] equal to its input event; div[k]=0 SHALL hold stage k at 0 with tick[k]=0, which also stops every later stage.
REQ-019 square[k] SHALL toggle on every tick[k], giving period 2*product(div[0..k]) clocks.
REQ-020 enable=0 SHALL hold all counters and square outputs and force tick to 0.
REQ-021 A write SHALL be accepted when div_wr_valid=1 and div_wr_ready=1, and SHALL be stored in a single pending slot; div_wr_ready SHALL be 0 while the slot is full or clear=1.
REQ-022 The pending divisor SHALL apply in the cycle the target stage wraps, or in the first cycle with enable=0, in which case that stage counter is also zeroed; the slot frees on the next cycle.
REQ-023 A write with div_wr_stage>=NUM_STAGES SHALL be accepted, discarded and set err=1.
REQ-024 clear=1 SHALL zero counters, square outputs and err, discard the pending write, and force tick to 0 that cycle; divisors are kept; clear has priority over enable and writes.

Reset
REQ-025 reset=0 SHALL asynchronously set counters=0, tick=0, square=0, div=DIV_RST, pending empty, div_wr_ready=1 and err=0.
REQ-026 Deassertion of reset SHALL be synchronous; counting starts on the first clock edge with reset=1 and enable=1.

Configuration
REQ-027 With FD_CHAIN_SQUARE_EN defined, the square toggle flops SHALL be built as in REQ-019; without it, square SHALL be tied to 0 and no flops inferred.

Structure
REQ-028 Package fd_chain_pkg SHALL hold the CNT_W default, MAX_STAGES=8, the default DIV_RST constant and the stage-index width.
REQ-029 Sub-module fd_stage (one counter, tick, square and divisor register) SHALL be instantiated NUM_STAGES times by generate; fd_chain holds the write slot and err.

Verification
REQ-030 Defaults, enable=1 for 200 clocks: tick[0] every 5th clock, tick[1] every 50th clock coincident with tick[0], tick[2]==tick[1], square[0] period 10.
REQ-031 Write stage1=4 mid-count: div_wr_ready=0 until the stage-1 wrap, tick[1] period becomes 20 from the next wrap, and no short period occurs.
REQ-032 enable=0 for 7 clocks mid-count: ticks stay 0, counts resume exactly, and a pending write applies during the pause with stage zeroed.
REQ-033 Write stage=5 with NUM_STAGES=3: accepted, no divisor changes, err=1 until clear; clear with simultaneous valid write: ready=0 and write ignored.
REQ-034 Write stage0=0: all ticks cease; rewrite 3: tick[0] period 3. Assert reset mid-count: all outputs 0 immediately, divisors revert to DIV_RST.

Source files
------------

// File: rtl/fd_chain_pkg.sv
// Shared constants and types for the cascaded frequency-divider chain.
package fd_chain_pkg;
   localparam int CNT_W_DEF  = 8;
   localparam int MAX_STAGES = 8;
   localparam int STAGE_W    = $clog2(MAX_STAGES);

   localparam logic [23:0] DIV_RST_DEF = {8'd1, 8'd10, 8'd5};

   typedef logic [STAGE_W-1:0] stage_idx_t;
endpackage

// File: rtl/fd_stage.sv
// One divider stage: counter, divisor register and optional square toggle.
// Square flops exist only when FD_CHAIN_SQUARE_EN is defined.
module fd_stage
   import fd_chain_pkg::*;
#(
   parameter int               CNT_W    = CNT_W_DEF,
   parameter logic [CNT_W-1:0] DIV_INIT = '0
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             clear,
   input  logic             count_en,
   input  logic             load,
   input  logic [CNT_W-1:0] load_value,
   output logic             last,
   output logic             square
);

   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] div;
   logic             wrap;

   // A zero divisor never reaches its last count, so it never ticks.
   assign last = (div != '0) && (cnt == div - CNT_W'(1));
   assign wrap = count_en & last;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         cnt <= '0;
         div <= DIV_INIT;
      end else if (clear) begin
         cnt <= '0;
      end else if (load) begin
         div <= load_value;
         cnt <= '0;
      end else if (count_en) begin
         if (wrap || div == '0)
            cnt <= '0;
         else
            cnt <= cnt + CNT_W'(1);
      end
   end

`ifdef FD_CHAIN_SQUARE_EN
   logic sq;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset)
         sq <= 1'b0;
      else if (clear)
         sq <= 1'b0;
      else if (wrap)
         sq <= ~sq;
   end

   assign square = sq;
`else
   assign square = 1'b0;
`endif

endmodule

// File: rtl/fd_chain.sv
// Cascaded frequency divider with a single-slot divisor write port.
// Define FD_CHAIN_SQUARE_EN to build the per-stage square outputs.
module fd_chain
   import fd_chain_pkg::*;
#(
   parameter int NUM_STAGES = 3,
   parameter int CNT_W      = CNT_W_DEF,
   parameter logic [NUM_STAGES*CNT_W-1:0] DIV_RST = DIV_RST_DEF
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  enable,
   input  logic                  clear,
   input  logic                  div_wr_valid,
   input  logic [STAGE_W-1:0]    div_wr_stage,
   input  logic [CNT_W-1:0]      div_wr_value,
   output logic                  div_wr_ready,
   output logic [NUM_STAGES-1:0] tick,
   output logic [NUM_STAGES-1:0] square,
   output logic                  err
);

   localparam logic [STAGE_W:0] N_ST = NUM_STAGES[STAGE_W:0];

   logic                  pend_valid;
   stage_idx_t            pend_stage;
   logic [CNT_W-1:0]      pend_value;
   logic [NUM_STAGES-1:0] last;
   logic [NUM_STAGES-1:0] count_en;
   logic [NUM_STAGES-1:0] load;
   logic                  run;
   logic                  wr_fire;
   logic                  wr_bad;
   logic                  applied;

   assign div_wr_ready = ~pend_valid & ~clear;
   assign wr_fire      = div_wr_valid & div_wr_ready;
   assign wr_bad       = {1'b0, div_wr_stage} >= N_ST;
   assign applied      = |load;

   // Zero-latency carry: each stage ticks in the same cycle as its feeder.
   always_comb begin
      count_en = '0;
      tick     = '0;
      run      = enable & ~clear;
      for (int k = 0; k < NUM_STAGES; k++) begin
         count_en[k] = run;
         run         = run & last[k];
         tick[k]     = run;
      end
   end

   for (genvar k = 0; k < NUM_STAGES; k++) begin : g_stage
      assign load[k] = pend_valid & ~clear
                     & (pend_stage == stage_idx_t'(k))
                     & (~enable | tick[k]);

      fd_stage #(
         .CNT_W    (CNT_W),
         .DIV_INIT (DIV_RST[k*CNT_W +: CNT_W])
      ) u_stage (
         .clock      (clock),
         .reset      (reset),
         .clear      (clear),
         .count_en   (count_en[k]),
         .load       (load[k]),
         .load_value (pend_value),
         .last       (last[k]),
         .square     (square[k])
      );
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         pend_valid <= 1'b0;
         pend_stage <= '0;
         pend_value <= '0;
         err        <= 1'b0;
      end else if (clear) begin
         pend_valid <= 1'b0;
         err        <= 1'b0;
      end else if (wr_fire) begin
         if (wr_bad) begin
            err <= 1'b1;
         end else begin
            pend_valid <= 1'b1;
            pend_stage <= div_wr_stage;
            pend_value <= div_wr_value;
         end
      end else if (applied) begin
         pend_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_fd_chain.sv
// Self-checking bench for fd_chain against a behavioural divider model.
// Square expectations follow FD_CHAIN_SQUARE_EN.
module tb_fd_chain;

   logic       clock = 1'b0;
   logic       reset = 1'b0;
   logic       enable = 1'b0;
   logic       clear = 1'b0;
   logic       div_wr_valid = 1'b0;
   logic [2:0] div_wr_stage = '0;
   logic [7:0] div_wr_value = '0;
   logic       div_wr_ready;
   logic [2:0] tick;
   logic [2:0] square;
   logic       err;

   int passed = 0;
   int total  = 0;
   int cyc    = 0;

   fd_chain dut (
      .clock        (clock),
      .reset        (reset),
      .enable       (enable),
      .clear        (clear),
      .div_wr_valid (div_wr_valid),
      .div_wr_stage (div_wr_stage),
      .div_wr_value (div_wr_value),
      .div_wr_ready (div_wr_ready),
      .tick         (tick),
      .square       (square),
      .err          (err)
   );

   always #5 clock = ~clock;

   // Model state: counts, divisors, square levels, pending slot, err.
   int   mcnt[3];
   int   mdiv[3];
   bit   msq[3];
   bit   mt[3];
   bit   mev[3];
   bit   mpend;
   bit   merr;
   bit   mready;
   int   mpst;
   int   mpval;
   bit   i_en, i_clr, i_v;
   int   i_st, i_val;
   logic [7:0] exp_v;

   function automatic void model_reset();
      mdiv  = '{5, 10, 1};
      mcnt  = '{0, 0, 0};
      msq   = '{0, 0, 0};
      mpend = 0;
      merr  = 0;
   endfunction

   task automatic drive(input bit en, input bit clr,
                        input bit v, input int st, input int val);
      bit         run;
      logic [2:0] et, es;
      enable = en;
      clear = clr;
      div_wr_valid = v;
      div_wr_stage = st[2:0];
      div_wr_value = val[7:0];
      i_en = en;
      i_clr = clr;
      i_v = v;
      i_st = st;
      i_val = val;
      run = en && !clr;
      for (int k = 0; k < 3; k++) begin
         mev[k] = run;
         mt[k]  = run && mdiv[k] != 0 && mcnt[k] == mdiv[k] - 1;
         run    = mt[k];
         et[k]  = mt[k];
`ifdef FD_CHAIN_SQUARE_EN
         es[k]  = msq[k];
`else
         es[k]  = 1'b0;
`endif
      end
      mready = !mpend && !clr;
      exp_v = {et, es, mready, merr};
      #1;
   endtask

   function automatic void model_update();
      bit appl = 0;
      if (i_clr) begin
         mcnt  = '{0, 0, 0};
         msq   = '{0, 0, 0};
         mpend = 0;
         merr  = 0;
         return;
      end
      for (int k = 0; k < 3; k++) begin
         if (mpend && mpst == k && (!i_en || mt[k])) begin
            mdiv[k] = mpval;
            mcnt[k] = 0;
            appl = 1;
         end else if (mev[k]) begin
            mcnt[k] = (mt[k] || mdiv[k] == 0) ? 0 : mcnt[k] + 1;
         end
         if (mt[k]) msq[k] = !msq[k];
      end
      if (i_v && mready) begin
         if (i_st >= 3) begin
            merr = 1;
         end else begin
            mpend = 1;
            mpst  = i_st;
            mpval = i_val;
         end
      end else if (appl) begin
         mpend = 0;
      end
   endfunction

   task automatic adv();
      @(posedge clock);
      model_update();
      cyc++;
      @(negedge clock);
   endtask

   task automatic test_reset();
      logic [7:0] obs;
      reset = 1'b0;
      #1;
      obs = {tick, square, div_wr_ready, err};
      total++;
      if (obs !== 8'b000000_1_0)
         $display("FAIL reset_state got=%b want=%b", obs, 8'b00000010);
      else passed++;
      model_reset();
      @(negedge clock);
      reset = 1'b1;
   endtask

   task automatic test_defaults();
      logic [7:0] obs;
      int n0 = 0, n1 = 0, n2 = 0;
      for (int i = 0; i < 200; i++) begin
         drive(1, 0, 0, 0, 0);
         obs = {tick, square, div_wr_ready, err};
         total++;
         if (obs !== exp_v)
            $display("FAIL defaults cyc=%0d got=%b want=%b",
                     cyc, obs, exp_v);
         else passed++;
         n0 += int'(tick[0]);
         n1 += int'(tick[1]);
         n2 += int'(tick[2]);
         adv();
      end
      total++;
      if (n0 != 40 || n1 != 4 || n2 != 4)
         $display("FAIL defaults_counts got=%0d/%0d/%0d want=40/4/4",
                  n0, n1, n2);
      else passed++;
   endtask

   task automatic test_write_mid();
      logic [7:0] obs;
      int t1[$];
      int mn = 1000;
      for (int i = 0; i < 140; i++) begin
         drive(1, 0, i == 23, 1, 4);
         obs = {tick, square, div_wr_ready, err};
         total++;
         if (obs !== exp_v)
            $display("FAIL write_mid cyc=%0d got=%b want=%b",
                     cyc, obs, exp_v);
         else passed++;
         if (i > 23 && tick[1]) t1.push_back(i);
         adv();
      end
      for (int j = 1; j < t1.size(); j++)
         if (t1[j] - t1[j-1] < mn) mn = t1[j] - t1[j-1];
      total++;
      if (t1.size() < 3 || mn != 20 || t1[$] - t1[$-1] != 20)
         $display("FAIL write_mid_period got=%0d n=%0d want=20",
                  mn, t1.size());
      else passed++;
   endtask

   task automatic test_pause();
      logic [7:0] obs;
      bit en;
      for (int i = 0; i < 100; i++) begin
         en = !(i >= 14 && i < 21);
         drive(en, 0, i == 13, 1, 6);
         obs = {tick, square, div_wr_ready, err};
         total++;
         if (obs !== exp_v)
            $display("FAIL pause cyc=%0d got=%b want=%b",
                     cyc, obs, exp_v);
         else passed++;
         if (!en) begin
            total++;
            if (tick !== 3'b000)
               $display("FAIL pause_tick got=%b want=000", tick);
            else passed++;
         end
         adv();
      end
   endtask

   task automatic test_err_clear();
      logic [7:0] obs;
      for (int i = 0; i < 40; i++) begin
         drive(1, i == 10, i == 1 || i == 10, i == 1 ? 5 : 0, 7);
         obs = {tick, square, div_wr_ready, err};
         total++;
         if (obs !== exp_v)
            $display("FAIL err_clear cyc=%0d got=%b want=%b",
                     cyc, obs, exp_v);
         else passed++;
         if (i == 2 || i == 10 || i == 11) begin
            total++;
            if ({div_wr_ready, err} !== (i == 2 ? 2'b11 : i == 10 ? 2'b01 : 2'b10))
               $display("FAIL err_flag i=%0d got=%b", i,
                        {div_wr_ready, err});
            else passed++;
         end
         adv();
      end
   endtask

   task automatic test_div_zero();
      logic [7:0] obs;
      int nz = 0, n0 = 0;
      for (int i = 0; i < 80; i++) begin
         drive(i != 45, 0, i == 0 || i == 42, 0, i == 0 ? 0 : 3);
         obs = {tick, square, div_wr_ready, err};
         total++;
         if (obs !== exp_v)
            $display("FAIL div_zero cyc=%0d got=%b want=%b",
                     cyc, obs, exp_v);
         else passed++;
         if (i >= 10 && i < 45) nz += int'(tick != 0);
         if (i >= 46 && i < 76) n0 += int'(tick[0]);
         adv();
      end
      total++;
      if (nz != 0 || n0 != 10)
         $display("FAIL div_zero_counts got=%0d/%0d want=0/10", nz, n0);
      else passed++;
   endtask

   task automatic test_reset_mid();
      logic [7:0] obs;
      int n0 = 0;
      for (int i = 0; i < 17; i++) begin
         drive(1, 0, i == 0, 6, 0);
         adv();
      end
      enable = 1'b1;
      #2 reset = 1'b0;
      #1;
      obs = {tick, square, div_wr_ready, err};
      total++;
      if (obs !== 8'b000000_1_0)
         $display("FAIL reset_mid got=%b want=%b", obs, 8'b00000010);
      else passed++;
      model_reset();
      @(negedge clock);
      reset = 1'b1;
      for (int i = 0; i < 60; i++) begin
         drive(1, 0, 0, 0, 0);
         obs = {tick, square, div_wr_ready, err};
         total++;
         if (obs !== exp_v)
            $display("FAIL reset_mid_run cyc=%0d got=%b want=%b",
                     cyc, obs, exp_v);
         else passed++;
         n0 += int'(tick[0]);
         adv();
      end
      total++;
      if (n0 != 12)
         $display("FAIL reset_mid_div got=%0d want=12", n0);
      else passed++;
   endtask

   task automatic test_random();
      logic [7:0] obs;
      for (int i = 0; i < 400; i++) begin
         drive($urandom_range(0, 9) != 0,
               $urandom_range(0, 49) == 0,
               $urandom_range(0, 5) == 0,
               int'($urandom_range(0, 3)),
               int'($urandom_range(0, 4)));
         obs = {tick, square, div_wr_ready, err};
         total++;
         if (obs !== exp_v)
            $display("FAIL random cyc=%0d got=%b want=%b",
                     cyc, obs, exp_v);
         else passed++;
         adv();
      end
   endtask

   initial begin
      test_reset();
      test_defaults();
      test_write_mid();
      test_pause();
      test_err_clear();
      test_div_zero();
      test_reset_mid();
      test_random();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
